// File: rtl/arb8_sched.sv
// Eight-requester arbiter with hold-until-release grants, a hold limit and a gap cycle between grants.
// Define RR_EN to rotate priority from the last owner; otherwise the highest index always wins.
module arb8_sched #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       gnt_nxt;
    logic [2:0]       id_nxt;
    logic             valid_nxt;
    logic             to_nxt;
    logic [2:0]       start_idx;
    logic [2:0]       win;
    logic             owner_rel;

`ifdef RR_EN
    logic [2:0] last_id, last_nxt;
    // Search begins just below the previous owner so it goes to the back of the line.
    assign start_idx = last_id - 3'd1;
`else
    assign start_idx = 3'd7;
`endif

    // Descending search from start with wrap-around; first set bit wins.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start - 3'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win       = pick(req, start_idx);
    assign owner_rel = done || !req[gnt_id] || (cnt == HOLD_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        to_nxt    = 1'b0;
`ifdef RR_EN
        last_nxt  = last_id;
`endif
        case (state)
            IDLE, RELEASE: begin
                if (|req) begin
                    gnt_nxt   = 8'd1 << win;
                    id_nxt    = win;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end else begin
                    gnt_nxt   = 8'd0;
                    id_nxt    = 3'd0;
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (owner_rel) begin
                    // Timeout only when the limit alone caused the release.
                    to_nxt    = !done && req[gnt_id];
                    gnt_nxt   = 8'd0;
                    id_nxt    = 3'd0;
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
`ifdef RR_EN
                    last_nxt  = gnt_id;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = 8'd0;
                id_nxt    = 3'd0;
                state_nxt = IDLE;
            end
        endcase
        valid_nxt = |gnt_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef RR_EN
            last_id   <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= id_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= to_nxt;
`ifdef RR_EN
            last_id   <= last_nxt;
`endif
        end
    end

endmodule
